serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, payload width per frame.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  DATA_BITS  payload; sampled only on frame acceptance.
REQ-006 start  input  1  level request; accepted only when idle.
REQ-007 tx  output  1  serial line; idle high; registered.
REQ-008 busy  output  1  high while a frame is on the line; registered.
REQ-009 done  output  1  one-cycle pulse at frame completion; registered.

Function
REQ-010 FSM states: IDLE, START, DATA, STOP; exactly one active.
REQ-011 IDLE: tx=1, busy=0; start=1 at an edge -> capture data into shift register, load bit timer, go START.
REQ-012 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-013 DATA: tx = captured bit[index], LSB first, each for CLKS_PER_BIT cycles; after bit DATA_BITS-1 go STOP.
REQ-014 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-015 Frame length: exactly (DATA_BITS+2)*CLKS_PER_BIT cycles of busy=1, starting the cycle after the accepting edge.
REQ-016 done=1 for exactly the first IDLE cycle after STOP; 0 at all other times.
REQ-017 start=1 in the done cycle is accepted; next START begins the following cycle (one idle-high cycle between frames).
REQ-018 start held high continuously produces back-to-back frames separated by one idle cycle each.
REQ-019 start while busy=1 is ignored; no queueing, no effect on current frame.
REQ-020 data changes after acceptance do not affect the frame in flight.
REQ-021 Bit timer counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS); no overflow beyond terminal values.
REQ-022 tx, busy, done are driven directly from flops; no combinational path from start/data to outputs.

Reset
REQ-023 reset=1 at an edge: state IDLE, tx=1, busy=0, done=0, timer=0, index=0, shift register=0.
REQ-024 reset overrides all else, including mid-frame and coincident start; aborted frame emits no done.
REQ-025 First edge with reset=0 and start=1 is a valid acceptance.

Structure
REQ-026 Shared package serial_pkg holds state enumeration type and default constants (CLKS_PER_BIT_DEFAULT=434, DATA_BITS_DEFAULT=8).
REQ-027 One sub-module bit_timer: loadable cycle counter with synchronous clear, emits a one-cycle tick at CLKS_PER_BIT-1; serial_tx instantiates exactly one.
REQ-028 Single clock domain; no latches, no gated clocks.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-029 Reset then start pulse with data=0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles; done one cycle after.
REQ-030 start held high, data=0x00 then 0xFF after acceptance -> first frame carries 0x00; second frame 0xFF begins 1 idle cycle after first done.
REQ-031 start pulsed at cycle 10 of a frame -> ignored; frame length unchanged; no extra frame.
REQ-032 reset asserted at cycle 20 of a frame -> next cycle tx=1, busy=0, done never pulses for that frame.
REQ-033 CLKS_PER_BIT=2, data=0x01 -> tx 0,1,0,0,0,0,0,0,0,1 each 2 cycles; busy 20 cycles.
REQ-034 reset and start both high at same edge -> stays IDLE, tx=1, busy=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial transmitter.
package serial_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS_DEFAULT    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last cycle.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, DATA_BITS payload LSB first, one stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [IW-1:0]        index, index_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_n, busy_n, done_n;
  logic                 accept, tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_comb begin
    state_n = state;
    index_n = index;
    shift_n = shift;
    accept  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          shift_n = data;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          index_n = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (index == LAST_BIT) state_n = STOP;
          else                   index_n = index + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are precomputed from the next state so tx/busy/done come straight from flops.
    busy_n = (state_n != IDLE);
    tx_n   = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[index_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      shift <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      shift <= shift_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues expected frames, a monitor decodes the line.
module tb_serial_tx;

  typedef struct {
    logic [7:0] d;
    int         len;
    bit         aborted;
    int         gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset, start_a, start_b, sel;
  logic [7:0] data_a, data_b;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  frame_t q[$];

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_a (
    .clock(clk), .reset(reset), .data(data_a), .start(start_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut_b (
    .clock(clk), .reset(reset), .data(data_b), .start(start_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  // Monitor: decodes whichever DUT is selected, checks per-cycle line bits, length, done and gap.
  logic   prev_busy = 1'b0;
  bit     have_cur  = 1'b0;
  frame_t cur;
  int     bcnt = 0;
  int     idle_cnt = 0;

  always @(negedge clk) begin
    logic mb, mt, md, eb;
    int   cpb, p;
    mb  = sel ? busy_b : busy_a;
    mt  = sel ? tx_b   : tx_a;
    md  = sel ? done_b : done_a;
    cpb = sel ? 2 : 4;
    if (mb === 1'b1 && prev_busy === 1'b0) begin
      bcnt = 0;
      if (q.size() == 0) begin
        checks++; errors++; have_cur = 1'b0;
        $display("FAIL unexpected_frame: busy rose with no frame expected");
      end else begin
        cur = q.pop_front();
        have_cur = 1'b1;
        if (cur.gap >= 0) begin
          checks++;
          if (idle_cnt != cur.gap) begin
            errors++;
            $display("FAIL idle_gap: got %0d idle cycles, expected %0d", idle_cnt, cur.gap);
          end
        end
      end
    end
    if (mb === 1'b1) begin
      bcnt++;
      if (have_cur) begin
        p = (bcnt - 1) / cpb;
        if (p == 0)      eb = 1'b0;
        else if (p <= 8) eb = cur.d[p-1];
        else             eb = 1'b1;
        checks++;
        if (mt !== eb) begin
          errors++;
          $display("FAIL tx_bit: frame %h cycle %0d tx=%b expected %b", cur.d, bcnt, mt, eb);
        end
      end
    end
    if (mb === 1'b0 && prev_busy === 1'b1) begin
      if (have_cur) begin
        checks++;
        if (bcnt != cur.len) begin
          errors++;
          $display("FAIL frame_len: frame %h busy %0d cycles, expected %0d", cur.d, bcnt, cur.len);
        end
        checks++;
        if (md !== !cur.aborted) begin
          errors++;
          $display("FAIL done_end: frame %h done=%b expected %b", cur.d, md, !cur.aborted);
        end
        checks++;
        if (mt !== 1'b1) begin
          errors++;
          $display("FAIL idle_tx: tx=%b expected 1 after frame %h", mt, cur.d);
        end
      end
      have_cur = 1'b0;
      idle_cnt = 1;
    end else begin
      checks++;
      if (md !== 1'b0) begin
        errors++;
        $display("FAIL done_spurious: done=%b expected 0 (busy=%b)", md, mb);
      end
      if (mb === 1'b0) idle_cnt++;
    end
    prev_busy = mb;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input int len, input bit ab, input int gap);
    frame_t f;
    f.d = d; f.len = len; f.aborted = ab; f.gap = gap;
    q.push_back(f);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    step(3);
    chk("reset_tx_a", tx_a, 1'b1);
    chk("reset_busy_a", busy_a, 1'b0);
    chk("reset_done_a", done_a, 1'b0);
    chk("reset_tx_b", tx_b, 1'b1);
    chk("reset_busy_b", busy_b, 1'b0);

    // First edge out of reset with start high is an acceptance; data change afterwards is ignored.
    reset = 1'b0; start_a = 1'b1; data_a = 8'hA5;
    push(8'hA5, 40, 1'b0, -1);
    step(1);
    start_a = 1'b0; data_a = 8'h3C;
    step(45);

    // Start held high: back-to-back frames with one idle cycle between them.
    start_a = 1'b1; data_a = 8'h00;
    push(8'h00, 40, 1'b0, -1);
    push(8'hFF, 40, 1'b0, 1);
    step(1);
    data_a = 8'hFF;
    step(41);
    start_a = 1'b0;
    step(45);

    // Start pulse mid-frame is ignored.
    start_a = 1'b1; data_a = 8'h5A;
    push(8'h5A, 40, 1'b0, -1);
    step(1);
    start_a = 1'b0;
    step(9);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(40);

    // Reset at busy cycle 20 aborts the frame with no done.
    start_a = 1'b1; data_a = 8'hC3;
    push(8'hC3, 20, 1'b1, -1);
    step(1);
    start_a = 1'b0;
    step(19);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort_tx", tx_a, 1'b1);
    chk("abort_busy", busy_a, 1'b0);
    step(10);

    // Reset and start coincident: stays idle.
    reset = 1'b1; start_a = 1'b1;
    step(1);
    chk("rst_start_tx", tx_a, 1'b1);
    chk("rst_start_busy", busy_a, 1'b0);
    reset = 1'b0; start_a = 1'b0;
    step(1);
    chk("rst_start_busy2", busy_a, 1'b0);
    step(5);

    // Two clocks per bit variant.
    sel = 1'b1;
    step(1);
    start_b = 1'b1; data_b = 8'h01;
    push(8'h01, 20, 1'b0, -1);
    step(1);
    start_b = 1'b0;
    step(25);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing: %0d expected frames never seen", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
